// File: rtl/atmr_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atmr_mon_pkg                                                         |
// | Shared constants, status encoding and helpers for the ATMR vote      |
// | monitor and its log FIFO.                                            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package atmr_mon_pkg;

  localparam int DEF_W            = 10;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_FAULT_THRESH = 4;
  localparam int DEF_LOG_DEPTH    = 4;

  // Log entry layout: {sample_idx[IDX_W-1:0], dis[DIS_W-1:0], syndrome[W-1:0]}
  localparam int NUM_REPL = 3;
  localparam int IDX_W    = 8;
  localparam int DIS_W    = NUM_REPL;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_FAILED   = 2'b10
  } status_e;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/atmr_vote_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atmr_vote_monitor_if                                                 |
// | Replica sample bus and mismatch-log handshake of the vote monitor.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface atmr_vote_monitor_if
  import atmr_mon_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LOG_W = IDX_W + DIS_W + W
);

  logic             in_valid;
  logic [W-1:0]     ori_z;
  logic [W-1:0]     mai_z;
  logic [W-1:0]     men_z;
  logic             log_valid;
  logic             log_ready;
  logic [LOG_W-1:0] log_data;

  modport master (
    output in_valid, ori_z, mai_z, men_z, log_ready,
    input  log_valid, log_data
  );

  modport slave (
    input  in_valid, ori_z, mai_z, men_z, log_ready,
    output log_valid, log_data
  );

endinterface
`default_nettype wire

// File: rtl/atmr_log_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atmr_log_fifo                                                        |
// | First-word-fall-through FIFO for mismatch log entries. A push into a |
// | full FIFO is dropped (flagged on drop) unless a pop happens in the   |
// | same cycle. DEPTH must be a power of two, at least 2.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module atmr_log_fifo #(
  parameter int DW    = 21,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          drop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [DW-1:0] mem_q [DEPTH];

  assign out_valid = (wr_ptr_q != rd_ptr_q);
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];

  // Occupancy, handshake and pointer advance; a pop frees the slot a full push needs.
  always_comb begin
    fill     = wr_ptr_q - rd_ptr_q;
    full     = (fill == DEPTH_V);
    pop      = out_valid & out_ready;
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/atmr_vote_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atmr_vote_monitor                                                    |
// | 2-of-3 bitwise voter over the ori/mai/men replicas with per-replica  |
// | mismatch counters, sticky fault flags, a health status FSM and a     |
// | mismatch log FIFO.                                                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module atmr_vote_monitor
  import atmr_mon_pkg::*;
#(
  parameter int W            = DEF_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FAULT_THRESH = DEF_FAULT_THRESH,
  parameter int LOG_DEPTH    = DEF_LOG_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  atmr_vote_monitor_if.slave  bus,
  input  logic                clr_req,
  output logic [W-1:0]        z_q,
  output logic                z_valid,
  output logic [CNT_W-1:0]    err_cnt_ori,
  output logic [CNT_W-1:0]    err_cnt_mai,
  output logic [CNT_W-1:0]    err_cnt_men,
  output logic [2:0]          fault,
  output logic [1:0]          status,
  output logic                log_ovf
);

  localparam int                LOG_W    = IDX_W + DIS_W + W;
  localparam int                CONS_W   = $clog2(FAULT_THRESH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CONS_W-1:0] CONS_LIM = CONS_W'(FAULT_THRESH);

  logic                             run_q;
  logic                             accept;
  logic [NUM_REPL-1:0][W-1:0]       repl;
  logic [W-1:0]                     vote;
  logic [W-1:0]                     syndrome;
  logic [NUM_REPL-1:0]              dis;
  logic [W-1:0]                     z_d;
  logic                             z_valid_q, z_valid_d;
  logic [IDX_W-1:0]                 sample_idx_q, sample_idx_d;
  logic [NUM_REPL-1:0][CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [NUM_REPL-1:0][CONS_W-1:0]  cons_q, cons_d;
  logic [NUM_REPL-1:0]              fault_q, fault_d;
  logic                             log_ovf_q, log_ovf_d;
  logic [1:0]                       n_fault;
  status_e                          state_q, state_d;
  logic                             log_push;
  logic                             log_drop;
  logic [LOG_W-1:0]                 log_entry;

  assign repl[0] = bus.ori_z;
  assign repl[1] = bus.mai_z;
  assign repl[2] = bus.men_z;

  assign accept    = bus.in_valid & run_q;
  assign log_push  = accept & (|dis);
  assign log_entry = {sample_idx_q, dis, syndrome};
  assign n_fault   = popcount3(fault_d);

  assign z_valid     = z_valid_q;
  assign err_cnt_ori = err_cnt_q[0];
  assign err_cnt_mai = err_cnt_q[1];
  assign err_cnt_men = err_cnt_q[2];
  assign fault       = fault_q;
  assign status      = state_q;
  assign log_ovf     = log_ovf_q;

  // Re-time reset release so the first sample is taken on the second edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Bitwise majority, per-replica disagreement flags and the combined syndrome.
  always_comb begin
    vote     = (repl[0] & repl[1]) | (repl[0] & repl[2]) | (repl[1] & repl[2]);
    syndrome = '0;
    dis      = '0;
    for (int r = 0; r < NUM_REPL; r++) begin
      dis[r]   = |(repl[r] ^ vote);
      syndrome = syndrome | (repl[r] ^ vote);
    end
  end

  // Sample path: result and index advance only on accepted samples; clr_req leaves them alone.
  always_comb begin
    z_d          = z_q;
    z_valid_d    = accept;
    sample_idx_d = sample_idx_q;
    if (accept) begin
      z_d          = vote;
      sample_idx_d = sample_idx_q + IDX_W'(1);
    end
  end

  // Health bookkeeping on the same edge as z_valid so counters line up with the voted sample.
  always_comb begin
    err_cnt_d = err_cnt_q;
    cons_d    = cons_q;
    fault_d   = fault_q;
    log_ovf_d = log_ovf_q | log_drop;
    if (clr_req) begin
      err_cnt_d = '0;
      cons_d    = '0;
      fault_d   = '0;
      log_ovf_d = 1'b0;
    end else if (accept) begin
      for (int r = 0; r < NUM_REPL; r++) begin
        if (dis[r]) begin
          if (err_cnt_q[r] != CNT_MAX) err_cnt_d[r] = err_cnt_q[r] + CNT_W'(1);
          if (cons_q[r] != CONS_LIM)   cons_d[r]    = cons_q[r] + CONS_W'(1);
        end else begin
          cons_d[r] = '0;
        end
        if (cons_d[r] == CONS_LIM) fault_d[r] = 1'b1;
      end
    end
  end

  // Status next-state from the fault flags being written this cycle; FAILED only leaves on clr_req.
  always_comb begin
    state_d = state_q;
    if (clr_req) begin
      state_d = ST_OK;
    end else begin
      case (state_q)
        ST_OK: begin
          if (n_fault >= 2'd2)      state_d = ST_FAILED;
          else if (n_fault == 2'd1) state_d = ST_DEGRADED;
        end
        ST_DEGRADED: begin
          if (n_fault >= 2'd2) state_d = ST_FAILED;
        end
        ST_FAILED: state_d = ST_FAILED;
        default:   state_d = ST_OK;
      endcase
    end
  end

  // Sample path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q          <= '0;
      z_valid_q    <= 1'b0;
      sample_idx_q <= '0;
    end else begin
      z_q          <= z_d;
      z_valid_q    <= z_valid_d;
      sample_idx_q <= sample_idx_d;
    end
  end

  // Health registers and status state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      cons_q    <= '0;
      fault_q   <= '0;
      log_ovf_q <= 1'b0;
      state_q   <= ST_OK;
    end else begin
      err_cnt_q <= err_cnt_d;
      cons_q    <= cons_d;
      fault_q   <= fault_d;
      log_ovf_q <= log_ovf_d;
      state_q   <= state_d;
    end
  end

  atmr_log_fifo #(
    .DW    (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (log_push),
    .push_data (log_entry),
    .drop      (log_drop),
    .out_valid (bus.log_valid),
    .out_ready (bus.log_ready),
    .out_data  (bus.log_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_atmr_vote_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_atmr_vote_monitor                                                 |
// | Self-checking bench: vote table, directed corner sequences and       |
// | random traffic against a behavioural model.                          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_atmr_vote_monitor;

  localparam int W      = 10;
  localparam int CNT_W  = 8;
  localparam int THRESH = 4;
  localparam int DEPTH  = 4;
  localparam int LOG_W  = 8 + 3 + W;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_req = 1'b0;
  logic [W-1:0]     z_q;
  logic             z_valid;
  logic [CNT_W-1:0] err_cnt_ori, err_cnt_mai, err_cnt_men;
  logic [2:0]       fault;
  logic [1:0]       status;
  logic             log_ovf;

  atmr_vote_monitor_if #(.W(W)) bus ();

  atmr_vote_monitor #(
    .W(W), .CNT_W(CNT_W), .FAULT_THRESH(THRESH), .LOG_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_req(clr_req),
    .z_q(z_q), .z_valid(z_valid),
    .err_cnt_ori(err_cnt_ori), .err_cnt_mai(err_cnt_mai), .err_cnt_men(err_cnt_men),
    .fault(fault), .status(status), .log_ovf(log_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [W-1:0]     m_z;
  bit               m_zv;
  int               m_err[3];
  int               m_cons[3];
  bit [2:0]         m_fault;
  bit               m_ovf;
  int               m_idx;
  bit               m_run;
  logic [LOG_W-1:0] m_q[$];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] o;
    logic [W-1:0] mi;
    logic [W-1:0] me;
    logic [W-1:0] ez;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_vote(input logic [W-1:0] a, b, c);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
    return v;
  endfunction

  function automatic int exp_status();
    int n;
    n = int'(m_fault[0]) + int'(m_fault[1]) + int'(m_fault[2]);
    if (n >= 2) return 2;
    if (n == 1) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_z = '0; m_zv = 0; m_fault = '0; m_ovf = 0; m_idx = 0; m_run = 0;
    for (int r = 0; r < 3; r++) begin m_err[r] = 0; m_cons[r] = 0; end
    m_q.delete();
  endtask

  task automatic compare_all();
    chk("z_q", z_q, m_z);
    chk("z_valid", z_valid, m_zv);
    chk("err_cnt_ori", err_cnt_ori, m_err[0]);
    chk("err_cnt_mai", err_cnt_mai, m_err[1]);
    chk("err_cnt_men", err_cnt_men, m_err[2]);
    chk("fault", fault, m_fault);
    chk("status", status, exp_status());
    chk("log_ovf", log_ovf, m_ovf);
    chk("log_valid", bus.log_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("log_data", bus.log_data, m_q[0]);
  endtask

  // One clock cycle: drive at negedge, advance model at posedge, compare #1 later.
  task automatic step(input logic [W-1:0] o, mi, me, input bit v, c, rdy);
    logic [W-1:0] rv[3];
    logic [W-1:0] vt, syn;
    bit [2:0]     dis;
    bit           pop, acc, full_b;
    bus.ori_z = o; bus.mai_z = mi; bus.men_z = me;
    bus.in_valid = v; clr_req = c; bus.log_ready = rdy;
    #1;
    chk("log_valid_pre", bus.log_valid, m_q.size() != 0);
    @(posedge clk);
    rv = '{o, mi, me};
    pop    = (m_q.size() != 0) && rdy;
    full_b = (m_q.size() == DEPTH);
    acc    = m_run && v;
    m_run  = 1;
    vt  = ref_vote(o, mi, me);
    syn = '0;
    dis = '0;
    for (int r = 0; r < 3; r++) begin
      syn    = syn | (rv[r] ^ vt);
      dis[r] = (rv[r] != vt);
    end
    if (pop) void'(m_q.pop_front());
    if (acc && dis != 0) begin
      if (!full_b || pop) m_q.push_back({8'(m_idx), dis, syn});
      else m_ovf = 1;
    end
    if (c) begin
      for (int r = 0; r < 3; r++) begin m_err[r] = 0; m_cons[r] = 0; end
      m_fault = '0;
      m_ovf   = 0;
    end else if (acc) begin
      for (int r = 0; r < 3; r++) begin
        if (dis[r]) begin
          if (m_err[r] < SAT) m_err[r]++;
          m_cons[r]++;
          if (m_cons[r] >= THRESH) m_fault[r] = 1;
        end else begin
          m_cons[r] = 0;
        end
      end
    end
    if (acc) begin
      m_z   = vt;
      m_idx = (m_idx + 1) % 256;
    end
    m_zv = acc;
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_z_q"}, z_q, 0);
    chk({tag, "_z_valid"}, z_valid, 0);
    chk({tag, "_err"}, {err_cnt_ori, err_cnt_mai, err_cnt_men}, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_log_valid"}, bus.log_valid, 0);
    chk({tag, "_log_ovf"}, log_ovf, 0);
  endtask

  // Asserts reset at a negedge, checks the asynchronous clear, releases at the next negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0]     c2a5 = 10'h2A5;
  logic [LOG_W-1:0] e;
  int               n;

  initial begin
    bus.in_valid = 1'b0; bus.ori_z = '0; bus.mai_z = '0; bus.men_z = '0; bus.log_ready = 1'b0;
    tbl[0] = '{10'h2A5, 10'h2A5, 10'h2A5, 10'h2A5};
    tbl[1] = '{10'h3FF, 10'h000, 10'h000, 10'h000};
    tbl[2] = '{10'h3FF, 10'h3FF, 10'h000, 10'h3FF};
    tbl[3] = '{10'h0F0, 10'h0FF, 10'h00F, 10'h0FF};
    tbl[4] = '{10'h155, 10'h2AA, 10'h3FF, 10'h3FF};
    tbl[5] = '{10'h123, 10'h123, 10'h000, 10'h123};
    tbl[6] = '{10'h001, 10'h002, 10'h004, 10'h000};
    @(negedge clk);

    // Clean stream; first edge after release must ignore the sample
    do_reset("rst0");
    step(c2a5, c2a5, c2a5, 1, 0, 0);
    chk("first_edge_ignored", z_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step(c2a5, c2a5, c2a5, 1, 0, 0);
      chk("clean_z", z_q, 10'h2A5);
      chk("clean_zv", z_valid, 1);
    end
    chk("clean_err", {err_cnt_ori, err_cnt_mai, err_cnt_men}, 0);
    chk("clean_status", status, 0);
    chk("clean_nolog", bus.log_valid, 0);

    // Vote truth table, then hold with in_valid low
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].o, tbl[i].mi, tbl[i].me, 1, 0, 1);
      chk("tbl_z", z_q, tbl[i].ez);
    end
    step(10'h000, 10'h3FF, 10'h3FF, 0, 0, 1);
    chk("hold_z", z_q, 10'h000);
    chk("hold_zv", z_valid, 0);

    // mai bit3 stuck for four samples
    do_reset("rst1");
    step(c2a5, c2a5, c2a5, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(c2a5, c2a5 ^ 10'h008, c2a5, 1, 0, 0);
    chk("mai_z", z_q, 10'h2A5);
    chk("mai_err", err_cnt_mai, 4);
    chk("mai_fault", fault, 3'b010);
    chk("mai_status", status, 1);
    for (int i = 0; i < 4; i++) begin
      e = {8'(i), 3'b010, 10'h008};
      chk("mai_log", bus.log_data, e);
      step(c2a5, c2a5, c2a5, 0, 0, 1);
    end
    chk("mai_drained", bus.log_valid, 0);

    // ori: 3 bad, 1 clean, 3 bad; log blocked -> overflow
    do_reset("rst2");
    step(c2a5, c2a5, c2a5, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step((i == 3) ? c2a5 : (c2a5 ^ 10'h001), c2a5, c2a5, 1, 0, 0);
      if (i == 4) chk("ovf_not_yet", log_ovf, 0);
    end
    chk("ori_fault", fault, 3'b000);
    chk("ori_err", err_cnt_ori, 6);
    chk("ori_ovf", log_ovf, 1);

    // ori and men on disjoint bits -> FAILED, then clear keeps the log
    do_reset("rst3");
    step(c2a5, c2a5, c2a5, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(c2a5 ^ 10'h010, c2a5, c2a5 ^ 10'h100, 1, 0, 0);
    chk("two_z", z_q, 10'h2A5);
    chk("two_fault", fault, 3'b101);
    chk("two_status", status, 2);
    step(c2a5, c2a5, c2a5, 0, 1, 0);
    chk("clr_status", status, 0);
    chk("clr_err", {err_cnt_ori, err_cnt_mai, err_cnt_men}, 0);
    chk("clr_fault", fault, 0);
    chk("clr_log_kept", bus.log_valid, 1);
    n = 0;
    for (int k = 0; k < 8 && bus.log_valid; k++) begin
      step(c2a5, c2a5, c2a5, 0, 0, 1);
      n++;
    end
    chk("clr_entries", n, 4);

    // Saturation and index wrap
    do_reset("rst4");
    step(c2a5, c2a5, c2a5, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(c2a5 ^ 10'h001, c2a5, c2a5, 1, 0, 1);
    chk("sat_err", err_cnt_ori, 255);
    chk("sat_fault", fault, 3'b001);
    chk("sat_status", status, 1);
    step(c2a5, c2a5, c2a5, 0, 0, 1);
    chk("sat_drained", bus.log_valid, 0);
    step(c2a5 ^ 10'h001, c2a5, c2a5, 1, 0, 0);
    chk("wrap_idx", bus.log_data[LOG_W-1 -: 8], 44);
    chk("sat_hold", err_cnt_ori, 255);

    // Reset mid-stream with a full log
    do_reset("rst5");
    step(c2a5, c2a5, c2a5, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(c2a5, c2a5 ^ 10'h001, c2a5, 1, 0, 0);
    chk("full_valid", bus.log_valid, 1);
    bus.in_valid = 1'b1;
    do_reset("midrst");
    for (int i = 0; i < 3; i++) begin
      step(c2a5, c2a5, c2a5, 0, 0, 1);
      chk("post_rst_zv", z_valid, 0);
    end
    step(10'h155, 10'h155, 10'h0AA, 1, 0, 1);
    chk("post_rst_first", z_valid, 1);
    chk("post_rst_z", z_q, 10'h155);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] base, o, mi, me;
      base = W'($urandom);
      o  = base ^ (($urandom_range(0, 3) == 0) ? W'($urandom) : W'(0));
      mi = base ^ (($urandom_range(0, 3) == 0) ? W'($urandom) : W'(0));
      me = base ^ (($urandom_range(0, 3) == 0) ? W'($urandom) : W'(0));
      step(o, mi, me, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
